ghost_mode_array: RTL and testbench
===================================

// Module: ghost_mode_array
// PURPOSE
// - Per-ghost mode controller for N_GHOSTS ghosts.
// - Owns the frightened timer, its end-of-fright twinkle, the per-ghost "can be eaten" lock,
//   the eat-combo counter and pacman/ghost collision detection (same-tile and tile-swap).
// - Sits between the global scatter/chase scheduler and the ghost movement/render units.
//   One instance serves all ghosts.
// PARAMETERS
// - N_GHOSTS      4    number of ghost channels
// - POS_W         5    width of one tile coordinate
// - FRIGHT_TICKS  360  frightened duration in game ticks (>= TWINKLE_TICKS)
// - TWINKLE_TICKS 120  final ticks of fright during which twinkle is active
// - BLINK_TICKS   15   ticks per twinkle half-period
// - CROSS_DETECT  1    1 = also detect pacman/ghost tile swap within one step
// PORTS
// - clk            in  1              system clock
// - reset_n        in  1              async, active-low reset
// - restart_ghosts in  1              sync clear, same effect as reset
// - tick           in  1              game-tick enable; all timers advance only on tick
// - big_gum_eat    in  1              1-cycle pulse: pacman ate a big gum
// - general_mode   in  ghost_modes_t  scheduler mode, SCATTER or CHASE only
// - in_house       in  N_GHOSTS       ghost i is inside the ghost house
// - ghost_xpos     in  N_GHOSTS*POS_W packed tile x, ghost i at [i*POS_W +: POS_W]
// - ghost_ypos     in  N_GHOSTS*POS_W packed tile y
// - pacman_xpos    in  POS_W          pacman tile x
// - pacman_ypos    in  POS_W          pacman tile y
// - ghost_state    out N_GHOSTS*2     packed ghost_modes_t per ghost
// - ghost_twinkle  out N_GHOSTS       ghost i is AFFRAID and blink phase is high
// - fright_active  out 1              frightened timer running
// - ghost_eaten    out N_GHOSTS       1-cycle one-hot pulse: ghost i eaten this cycle
// - eat_combo      out 2              combo index of that eat (0..3 = 200/400/800/1600)
// - pacman_killed  out 1              1-cycle pulse: pacman hit by a non-frightened ghost
// BEHAVIOUR
// Reset and restart
// - reset_n low or restart_ghosts: all ghosts SCATTER; can_eat=0; fright counter=0;
//   blink phase=0; combo=0; previous positions = current inputs.
// - All outputs 0 / SCATTER.
// Fright timer
// - big_gum_eat: load FRIGHT_TICKS, clear combo, clear blink phase and blink counter,
//   set can_eat[i] for every ghost not EATEN.
// - A big_gum_eat while fright is running reloads the timer (restart, not extend).
// - On tick with counter>0: decrement. fright_active = (counter != 0).
// - When counter reaches 0: clear all can_eat.
// - Twinkle window: fright_active && counter <= TWINKLE_TICKS. Blink phase toggles every
//   BLINK_TICKS ticks inside the window and is held at 0 outside it.
// Collision, per ghost
// - hit[i] = same tile, OR (CROSS_DETECT and ghost_pos == pacman_prev and
//   pacman_pos == ghost_prev[i]).
// - prev registers update every cycle.
// Per-ghost FSM (registered, 1-cycle latency)
// - SCATTER/CHASE:
//   - if in_house[i]: hold.
//   - else if fright_active && can_eat[i]: AFFRAID.
//   - else: follow general_mode.
// - AFFRAID:
//   - if hit[i] and i is the lowest-index hit AFFRAID ghost: EATEN, pulse ghost_eaten[i],
//     drive eat_combo = combo, then combo saturating-increments (max 3).
//   - else if !fright_active: general_mode.
//   - else: hold.
// - EATEN:
//   - clears can_eat[i] on entry.
//   - if in_house[i]: general_mode. Re-fright needs a new big_gum_eat.
//   - else: hold. Collisions are ignored.
// Simultaneous events
// - Several AFFRAID ghosts hit in one cycle: only the lowest index is eaten. The others
//   stay AFFRAID and are re-evaluated next cycle (one eat per cycle, combo strictly ordered).
// - pacman_killed pulses when any ghost in SCATTER/CHASE, not in house, has hit.
//   It is suppressed when big_gum_eat is high in the same cycle.
// - big_gum_eat in the same cycle as an eat: the eat is processed with the old combo,
//   then the combo resets to 0.
// - Timer expiring in the same cycle as a hit on an AFFRAID ghost: the eat wins.
// - reset_n asserted mid-fright: immediate return to reset values, no pulses.
// TESTING
// 1. Reset, general_mode=CHASE, no in_house -> all ghost_state CHASE one cycle later;
//    all other outputs 0.
// 2. big_gum_eat, ghost1 on pacman tile next cycle -> ghost_eaten=4'b0010, eat_combo=0,
//    ghost1 EATEN, others AFFRAID.
// 3. FRIGHT_TICKS=8, TWINKLE_TICKS=4, BLINK_TICKS=1 with tick every cycle -> twinkle
//    toggles for the last 4 ticks; fright_active falls; ghosts return to general_mode.
// 4. Ghosts 0 and 2 AFFRAID on pacman tile together -> ghost0 eaten (combo 0), next cycle
//    ghost2 eaten (combo 1).
// 5. Pacman (3,4)->(4,4) while ghost (4,4)->(3,4), ghost in CHASE -> pacman_killed pulse.
//    With CROSS_DETECT=0 -> no pulse.
// 6. Eaten ghost reaches in_house, second big_gum_eat -> re-enters AFFRAID, combo restarts at 0.

Source files
------------

// File: rtl/ghost_mode_array.sv
// Per-ghost mode controller: fright timer with end-of-fright twinkle, per-ghost eat lock,
// eat-combo counter and pacman/ghost collision detection for all ghosts in one instance.
package ghost_mode_pkg;
  typedef enum logic [1:0] {
    SCATTER = 2'd0,
    CHASE   = 2'd1,
    AFFRAID = 2'd2,
    EATEN   = 2'd3
  } ghost_modes_t;
endpackage

module ghost_mode_array
  import ghost_mode_pkg::*;
#(
  parameter int N_GHOSTS      = 4,
  parameter int POS_W         = 5,
  parameter int FRIGHT_TICKS  = 360,
  parameter int TWINKLE_TICKS = 120,
  parameter int BLINK_TICKS   = 15,
  parameter int CROSS_DETECT  = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      restart_ghosts,
  input  logic                      tick,
  input  logic                      big_gum_eat,
  input  ghost_modes_t              general_mode,
  input  logic [N_GHOSTS-1:0]       in_house,
  input  logic [N_GHOSTS*POS_W-1:0] ghost_xpos,
  input  logic [N_GHOSTS*POS_W-1:0] ghost_ypos,
  input  logic [POS_W-1:0]          pacman_xpos,
  input  logic [POS_W-1:0]          pacman_ypos,
  output logic [N_GHOSTS*2-1:0]     ghost_state,
  output logic [N_GHOSTS-1:0]       ghost_twinkle,
  output logic                      fright_active,
  output logic [N_GHOSTS-1:0]       ghost_eaten,
  output logic [1:0]                eat_combo,
  output logic                      pacman_killed
);

  localparam int CNT_W = $clog2(FRIGHT_TICKS + 1);
  localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [CNT_W-1:0] FRIGHT_C   = CNT_W'(FRIGHT_TICKS);
  localparam logic [CNT_W-1:0] TWINKLE_C  = CNT_W'(TWINKLE_TICKS);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_TICKS - 1);

  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      blink_q, blink_d;
  logic [BLK_W-1:0]          blink_cnt_q, blink_cnt_d;
  logic [1:0]                combo_q, combo_d;
  logic [N_GHOSTS-1:0]       can_eat_q, can_eat_d;
  ghost_modes_t              mode_q [N_GHOSTS];
  ghost_modes_t              mode_d [N_GHOSTS];
  logic [N_GHOSTS-1:0]       eaten_q, eaten_d;
  logic [1:0]                eat_combo_q, eat_combo_d;
  logic                      killed_q, killed_d;

  logic [N_GHOSTS*POS_W-1:0] ghost_xprev_q, ghost_yprev_q;
  logic [POS_W-1:0]          pacman_xprev_q, pacman_yprev_q;
  logic                      prev_valid_q;

  logic [N_GHOSTS-1:0]       hit, eat_cand, eat_sel, kill_cand;
  logic                      twinkle_win;

  assign fright_active = (cnt_q != '0);
  assign twinkle_win   = fright_active && (cnt_q <= TWINKLE_C);

  // A tile swap means ghost and pacman each now stand where the other stood last cycle.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_GHOSTS; i++) begin
      hit[i] = ((ghost_xpos[i*POS_W +: POS_W] == pacman_xpos) &&
                (ghost_ypos[i*POS_W +: POS_W] == pacman_ypos)) ||
               ((CROSS_DETECT != 0) && prev_valid_q &&
                (ghost_xpos[i*POS_W +: POS_W] == pacman_xprev_q) &&
                (ghost_ypos[i*POS_W +: POS_W] == pacman_yprev_q) &&
                (pacman_xpos == ghost_xprev_q[i*POS_W +: POS_W]) &&
                (pacman_ypos == ghost_yprev_q[i*POS_W +: POS_W]));
    end
  end

  always_comb begin
    eat_cand  = '0;
    kill_cand = '0;
    for (int i = 0; i < N_GHOSTS; i++) begin
      eat_cand[i]  = (mode_q[i] == AFFRAID) && hit[i];
      kill_cand[i] = ((mode_q[i] == SCATTER) || (mode_q[i] == CHASE)) && !in_house[i] && hit[i];
    end
    eat_sel = eat_cand & (~eat_cand + N_GHOSTS'(1));
  end

  always_comb begin
    for (int i = 0; i < N_GHOSTS; i++) begin
      mode_d[i] = mode_q[i];
      case (mode_q[i])
        SCATTER, CHASE: begin
          if (!in_house[i]) begin
            if (fright_active && can_eat_q[i]) mode_d[i] = AFFRAID;
            else                               mode_d[i] = general_mode;
          end
        end
        AFFRAID: begin
          if (eat_sel[i])          mode_d[i] = EATEN;
          else if (!fright_active) mode_d[i] = general_mode;
        end
        EATEN: begin
          if (in_house[i]) mode_d[i] = general_mode;
        end
        default: mode_d[i] = SCATTER;
      endcase
    end
  end

  // Timer, blink, eat lock and combo; an eat in a big-gum cycle still reports the old combo.
  always_comb begin
    cnt_d       = cnt_q;
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    combo_d     = combo_q;
    can_eat_d   = can_eat_q;
    if (big_gum_eat) begin
      cnt_d       = FRIGHT_C;
      blink_d     = 1'b0;
      blink_cnt_d = '0;
    end else begin
      if (tick && fright_active) cnt_d = cnt_q - CNT_W'(1);
      if (!twinkle_win) begin
        blink_d     = 1'b0;
        blink_cnt_d = '0;
      end else if (tick) begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_d     = ~blink_q;
          blink_cnt_d = '0;
        end else begin
          blink_cnt_d = blink_cnt_q + BLK_W'(1);
        end
      end
    end
    if (|eat_sel) combo_d = (combo_q == 2'd3) ? 2'd3 : combo_q + 2'd1;
    if (big_gum_eat) begin
      combo_d = 2'd0;
      for (int i = 0; i < N_GHOSTS; i++) can_eat_d[i] = (mode_q[i] != EATEN);
    end else if (cnt_d == '0) begin
      can_eat_d = '0;
    end
    can_eat_d   = can_eat_d & ~eat_sel;
    eaten_d     = eat_sel;
    eat_combo_d = (|eat_sel) ? combo_q : 2'd0;
    killed_d    = (|kill_cand) && !big_gum_eat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
      combo_q     <= 2'd0;
      can_eat_q   <= '0;
      eaten_q     <= '0;
      eat_combo_q <= 2'd0;
      killed_q    <= 1'b0;
      for (int i = 0; i < N_GHOSTS; i++) mode_q[i] <= SCATTER;
    end else if (restart_ghosts) begin
      cnt_q       <= '0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
      combo_q     <= 2'd0;
      can_eat_q   <= '0;
      eaten_q     <= '0;
      eat_combo_q <= 2'd0;
      killed_q    <= 1'b0;
      for (int i = 0; i < N_GHOSTS; i++) mode_q[i] <= SCATTER;
    end else begin
      cnt_q       <= cnt_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      combo_q     <= combo_d;
      can_eat_q   <= can_eat_d;
      eaten_q     <= eaten_d;
      eat_combo_q <= eat_combo_d;
      killed_q    <= killed_d;
      for (int i = 0; i < N_GHOSTS; i++) mode_q[i] <= mode_d[i];
    end
  end

  // Swap detection stays off until one real sample exists, matching "previous = current".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ghost_xprev_q  <= '0;
      ghost_yprev_q  <= '0;
      pacman_xprev_q <= '0;
      pacman_yprev_q <= '0;
      prev_valid_q   <= 1'b0;
    end else begin
      ghost_xprev_q  <= ghost_xpos;
      ghost_yprev_q  <= ghost_ypos;
      pacman_xprev_q <= pacman_xpos;
      pacman_yprev_q <= pacman_ypos;
      prev_valid_q   <= 1'b1;
    end
  end

  always_comb begin
    ghost_state   = '0;
    ghost_twinkle = '0;
    for (int i = 0; i < N_GHOSTS; i++) begin
      ghost_state[i*2 +: 2] = mode_q[i];
      ghost_twinkle[i]      = (mode_q[i] == AFFRAID) && blink_q && twinkle_win;
    end
  end

  assign ghost_eaten   = eaten_q;
  assign eat_combo     = eat_combo_q;
  assign pacman_killed = killed_q;

endmodule

// File: tb/tb_ghost_mode_array.sv
// Scoreboard bench for ghost_mode_array: scripted stimulus pushes expected outputs,
// which are popped and compared one cycle later. A second instance has swap detection off.
module tb_ghost_mode_array;
  import ghost_mode_pkg::*;

  localparam int N  = 4;
  localparam int PW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n, restart_ghosts, tick, big_gum_eat;
  ghost_modes_t      general_mode;
  logic [N-1:0]      in_house;
  logic [N*PW-1:0]   ghost_xpos, ghost_ypos;
  logic [PW-1:0]     pacman_xpos, pacman_ypos;

  logic [N*2-1:0]    ghost_state, nc_state;
  logic [N-1:0]      ghost_twinkle, nc_twinkle, ghost_eaten, nc_eaten;
  logic              fright_active, nc_fright, pacman_killed, nc_killed;
  logic [1:0]        eat_combo, nc_combo;

  ghost_mode_array #(.N_GHOSTS(N), .POS_W(PW), .FRIGHT_TICKS(8), .TWINKLE_TICKS(4),
                     .BLINK_TICKS(1), .CROSS_DETECT(1)) dut (
    .clk(clk), .reset_n(reset_n), .restart_ghosts(restart_ghosts), .tick(tick),
    .big_gum_eat(big_gum_eat), .general_mode(general_mode), .in_house(in_house),
    .ghost_xpos(ghost_xpos), .ghost_ypos(ghost_ypos),
    .pacman_xpos(pacman_xpos), .pacman_ypos(pacman_ypos),
    .ghost_state(ghost_state), .ghost_twinkle(ghost_twinkle), .fright_active(fright_active),
    .ghost_eaten(ghost_eaten), .eat_combo(eat_combo), .pacman_killed(pacman_killed));

  ghost_mode_array #(.N_GHOSTS(N), .POS_W(PW), .FRIGHT_TICKS(8), .TWINKLE_TICKS(4),
                     .BLINK_TICKS(1), .CROSS_DETECT(0)) dutNoCross (
    .clk(clk), .reset_n(reset_n), .restart_ghosts(restart_ghosts), .tick(tick),
    .big_gum_eat(big_gum_eat), .general_mode(general_mode), .in_house(in_house),
    .ghost_xpos(ghost_xpos), .ghost_ypos(ghost_ypos),
    .pacman_xpos(pacman_xpos), .pacman_ypos(pacman_ypos),
    .ghost_state(nc_state), .ghost_twinkle(nc_twinkle), .fright_active(nc_fright),
    .ghost_eaten(nc_eaten), .eat_combo(nc_combo), .pacman_killed(nc_killed));

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } expect_t;

  expect_t sbQueue[$];
  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return 32'(ghost_state);
      1:       return 32'(ghost_twinkle);
      2:       return 32'(fright_active);
      3:       return 32'(ghost_eaten);
      4:       return 32'(eat_combo);
      5:       return 32'(pacman_killed);
      default: return 32'(nc_killed);
    endcase
  endfunction

  task automatic applyStimulus(input logic rn, input logic rst, input logic tk,
                               input logic gum, input logic [N-1:0] house);
    reset_n        = rn;
    restart_ghosts = rst;
    tick           = tk;
    big_gum_eat    = gum;
    in_house       = house;
  endtask

  task automatic setGhost(input int i, input int x, input int y);
    ghost_xpos[i*PW +: PW] = PW'(x);
    ghost_ypos[i*PW +: PW] = PW'(y);
  endtask

  task automatic setPacman(input int x, input int y);
    pacman_xpos = PW'(x);
    pacman_ypos = PW'(y);
  endtask

  task automatic homeAll();
    for (int i = 0; i < N; i++) setGhost(i, 10 + i, 20);
  endtask

  task automatic expectOutputs(input string step, input logic [7:0] st, input logic [3:0] tw,
                               input logic fa, input logic [3:0] ea, input logic [1:0] co,
                               input logic ki, input logic kiNc);
    sbQueue.push_back('{{step, ".state"},   0, 32'(st)});
    sbQueue.push_back('{{step, ".twinkle"}, 1, 32'(tw)});
    sbQueue.push_back('{{step, ".fright"},  2, 32'(fa)});
    sbQueue.push_back('{{step, ".eaten"},   3, 32'(ea)});
    sbQueue.push_back('{{step, ".combo"},   4, 32'(co)});
    sbQueue.push_back('{{step, ".killed"},  5, 32'(ki)});
    sbQueue.push_back('{{step, ".killedNoCross"}, 6, 32'(kiNc)});
  endtask

  task automatic stepAndScore();
    expect_t e;
    @(posedge clk);
    #1;
    while (sbQueue.size() > 0) begin
      e = sbQueue.pop_front();
      checkOutput(e.tag, observe(e.sel), e.exp);
    end
  endtask

  initial begin
    general_mode = CHASE;
    homeAll();
    setPacman(1, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

    // Reset, then everyone follows CHASE.
    expectOutputs("R0", 8'h00, 4'h0, 0, 4'h0, 2'd0, 0, 0); stepAndScore();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    expectOutputs("R1", 8'h55, 4'h0, 0, 4'h0, 2'd0, 0, 0); stepAndScore();

    // Big gum, then ghost 1 eaten with combo 0; eaten ghost ignores collisions.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
    expectOutputs("A", 8'h55, 4'h0, 1, 4'h0, 2'd0, 0, 0); stepAndScore();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    expectOutputs("B", 8'hAA, 4'h0, 1, 4'h0, 2'd0, 0, 0); stepAndScore();
    setGhost(1, 1, 1);
    expectOutputs("C", 8'hAE, 4'h0, 1, 4'b0010, 2'd0, 0, 0); stepAndScore();
    expectOutputs("D", 8'hAE, 4'h0, 1, 4'h0, 2'd0, 0, 0); stepAndScore();

    // Two ghosts hit together: lowest index first, combo strictly ordered.
    setGhost(1, 11, 20); setGhost(0, 1, 1); setGhost(2, 1, 1);
    expectOutputs("E", 8'hAF, 4'h0, 1, 4'b0001, 2'd1, 0, 0); stepAndScore();
    expectOutputs("F", 8'hBF, 4'h0, 1, 4'b0100, 2'd2, 0, 0); stepAndScore();
    setGhost(0, 10, 20); setGhost(2, 12, 20); setGhost(3, 1, 1);
    expectOutputs("G", 8'hFF, 4'h0, 1, 4'b1000, 2'd3, 0, 0); stepAndScore();

    // Eaten ghosts reach the house and revert; only a new big gum re-frightens.
    setGhost(3, 13, 20);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b0010);
    expectOutputs("H", 8'hF7, 4'h0, 1, 4'h0, 2'd0, 0, 0); stepAndScore();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b1111);
    expectOutputs("I", 8'h55, 4'h0, 1, 4'h0, 2'd0, 0, 0); stepAndScore();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
    expectOutputs("J", 8'h55, 4'h0, 1, 4'h0, 2'd0, 0, 0); stepAndScore();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    expectOutputs("K", 8'hAA, 4'h0, 1, 4'h0, 2'd0, 0, 0); stepAndScore();
    setGhost(2, 1, 1);
    expectOutputs("L", 8'hBA, 4'h0, 1, 4'b0100, 2'd0, 0, 0); stepAndScore();

    // Timer runs down: twinkle over the last ticks, then expiry.
    setGhost(2, 12, 20);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
    expectOutputs("M", 8'hBA, 4'h0, 1, 4'h0, 2'd0, 0, 0); stepAndScore();
    expectOutputs("N", 8'hBA, 4'h0, 1, 4'h0, 2'd0, 0, 0); stepAndScore();
    expectOutputs("O", 8'hBA, 4'h0, 1, 4'h0, 2'd0, 0, 0); stepAndScore();
    expectOutputs("P", 8'hBA, 4'h0, 1, 4'h0, 2'd0, 0, 0); stepAndScore();
    expectOutputs("Q", 8'hBA, 4'b1011, 1, 4'h0, 2'd0, 0, 0); stepAndScore();
    expectOutputs("R", 8'hBA, 4'h0, 1, 4'h0, 2'd0, 0, 0); stepAndScore();
    expectOutputs("S", 8'hBA, 4'b1011, 1, 4'h0, 2'd0, 0, 0); stepAndScore();
    expectOutputs("T", 8'hBA, 4'h0, 0, 4'h0, 2'd0, 0, 0); stepAndScore();
    // Hit in the cycle the timer has just expired: the eat wins over reverting.
    setGhost(0, 1, 1);
    expectOutputs("U", 8'h77, 4'h0, 0, 4'b0001, 2'd1, 0, 0); stepAndScore();
    setGhost(0, 10, 20);
    expectOutputs("V", 8'h77, 4'h0, 0, 4'h0, 2'd0, 0, 0); stepAndScore();

    // Tile swap with a chasing ghost kills only when swap detection is on.
    setPacman(3, 4); setGhost(1, 4, 4);
    expectOutputs("W", 8'h77, 4'h0, 0, 4'h0, 2'd0, 0, 0); stepAndScore();
    setPacman(4, 4); setGhost(1, 3, 4);
    expectOutputs("X", 8'h77, 4'h0, 0, 4'h0, 2'd0, 1, 0); stepAndScore();
    expectOutputs("Y", 8'h77, 4'h0, 0, 4'h0, 2'd0, 0, 0); stepAndScore();

    // Same-tile kill is suppressed by a simultaneous big gum.
    setGhost(3, 4, 4);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'b0000);
    expectOutputs("Z", 8'h77, 4'h0, 1, 4'h0, 2'd0, 0, 0); stepAndScore();
    setGhost(3, 13, 20);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
    expectOutputs("AA", 8'hBB, 4'h0, 1, 4'h0, 2'd0, 0, 0); stepAndScore();
    setGhost(3, 4, 4);
    expectOutputs("AB", 8'hFB, 4'h0, 1, 4'b1000, 2'd0, 0, 0); stepAndScore();
    // Eat in a big-gum cycle reports the old combo.
    setGhost(3, 13, 20); setGhost(1, 4, 4);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'b0000);
    expectOutputs("AB2", 8'hFF, 4'h0, 1, 4'b0010, 2'd1, 0, 0); stepAndScore();

    // Synchronous restart, then asynchronous reset in the middle of fright.
    homeAll();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
    expectOutputs("AC", 8'h00, 4'h0, 0, 4'h0, 2'd0, 0, 0); stepAndScore();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
    expectOutputs("AD", 8'h55, 4'h0, 0, 4'h0, 2'd0, 0, 0); stepAndScore();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'b0000);
    expectOutputs("AE", 8'h55, 4'h0, 1, 4'h0, 2'd0, 0, 0); stepAndScore();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
    expectOutputs("AF", 8'hAA, 4'h0, 1, 4'h0, 2'd0, 0, 0); stepAndScore();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    expectOutputs("AG", 8'h00, 4'h0, 0, 4'h0, 2'd0, 0, 0); stepAndScore();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
    expectOutputs("AH", 8'h55, 4'h0, 0, 4'h0, 2'd0, 0, 0); stepAndScore();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
